tone_arbiter: RTL and testbench
===============================

Name: tone_arbiter

Overview:
- Shares the single tone generator (buzzer/PWM) among three requesters: player keys, memory playback and metronome click.
- Applies fixed priority, inserts a silence gap between articulations and times the metronome click.
- Sits between the mode control units and the tone generator, replacing ad-hoc ORing of `toca` and metronome enables.

Parameters:
- NOTE_W, 4, note index width (0 = silence code, never forwarded while a grant is active).
- GAP_CYCLES, 500000, silence length between articulations (10 ms at 50 MHz); legal range >= 1.
- CLICK_CYCLES, 2500000, metronome click duration (50 ms at 50 MHz); legal range >= 1.
- CLICK_NOTE, 4'hF, note index driven during a click.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  arbiter active; low forces IDLE, silence, pending click cleared
- req_jog  in  1  player key held (level)
- nota_jog  in  NOTE_W  player note
- req_mem  in  1  memory playback tone request (level)
- nota_mem  in  NOTE_W  memory note
- pulso_metro  in  1  metronome tick (single-cycle pulse)
- tone_en  out  1  tone generator enable
- tone_sel  out  NOTE_W  note to generator
- grant  out  3  one-hot {metro, mem, jog}
- click_perdido  out  1  one-cycle pulse when a pending click is discarded
- db_estado  out  3  current state

Behaviour:
- Reset / enable low: state IDLE; tone_en=0; tone_sel=0; grant=000; click_perdido=0; click_pend=0; counters=0.
- Registered Moore outputs: a request seen at edge N drives tone_en at edge N+1, i.e. one cycle latency.
- States: IDLE, PLAY_JOG, PLAY_MEM, CLICK, GAP.
- Priority: jog > mem > metro.
- IDLE transitions:
  - req_jog -> PLAY_JOG
  - else req_mem -> PLAY_MEM
  - else click_pend -> CLICK
  - else stay in IDLE.
- On entry to a PLAY state, the note is latched into nota_reg. tone_sel = nota_reg; tone_en=1; grant bit set.
- PLAY_JOG: leaves for GAP when req_jog falls or nota_jog != nota_reg (re-articulation).
- PLAY_MEM:
  - req_jog rises -> GAP (preemption; mem is not resumed automatically).
  - req_mem falls or nota_mem changes -> GAP.
- CLICK:
  - tone_sel=CLICK_NOTE; tone_en=1; grant=100.
  - click counter runs 0..CLICK_CYCLES-1, then the state goes to GAP. Dwell is exactly CLICK_CYCLES cycles.
  - req_jog or req_mem arriving during CLICK aborts it to GAP at the next edge.
- GAP:
  - tone_en=0; tone_sel=0; grant=000.
  - gap counter runs 0..GAP_CYCLES-1, then the state goes to IDLE, which re-arbitrates the next cycle.
  - Requests during GAP are not served early.
- click_pend:
  - Set by pulso_metro and cleared on CLICK entry.
  - A second pulse while pending is ignored (no queueing).
  - Staleness counter starts at the set and counts while pending. If CLICK is not entered within CLICK_CYCLES cycles, pend is cleared and click_perdido pulses for 1 cycle.
  - pulso_metro in the same cycle as a clear: the set wins.
- A note value of 0 with req high is forwarded as-is; no special-casing.
- Counters saturate-free: each is cleared on entry to its state, width = clog2 of its max parameter.
- Reset or enable low mid-operation: immediate return to IDLE with outputs silenced, no gap.

Optional Feature:
- Macro: TONE_ARBITER_MUTE_EN.
- When defined:
  - Adds input `mudo` (1 bit).
  - While high, tone_en is forced 0; the FSM, grant, tone_sel and counters run unchanged.
  - Muting does not alter timing.
- When undefined: no port, tone_en comes straight from the FSM.

Decomposition:
- Shared package `fpgaudio_pkg` holds:
  - state encoding constants (IDLE=3'd0, PLAY_JOG=3'd1, PLAY_MEM=3'd2, CLICK=3'd3, GAP=3'd4)
  - grant one-hot constants GNT_JOG=3'b001, GNT_MEM=3'b010, GNT_METRO=3'b100
  - NOTE_W default
  - the silence code.
- One sub-module: `tone_arb_timer`, a loadable up-counter with clear/enable and a terminal-count flag. It is instantiated for gap, click duration and click staleness.

Test Plan (GAP_CYCLES=4, CLICK_CYCLES=8):
- req_mem=1, nota_mem=5 at cycle 10 -> tone_en=1, tone_sel=5, grant=010 from cycle 11; req_mem=0 at 20 -> tone_en=0 for 4 cycles, then IDLE.
- PLAY_MEM with note 5; req_jog=1, nota_jog=9 at cycle 15 -> GAP at 16 for 4 cycles, then PLAY_JOG with tone_sel=9, grant=001; mem not resumed after jog releases unless req_mem still high.
- Idle, pulso_metro at cycle 3 -> CLICK at cycle 5 with tone_sel=F, lasting 8 cycles, then 4 gap cycles; second pulse at cycle 4 is ignored.
- req_jog held with a note sequence 2, 2, 7 -> gap inserted on the 2->7 change only; tone_sel=7 follows the gap.
- req_jog held 20 cycles, pulso_metro at cycle 2 -> click_perdido pulses at cycle 10; no CLICK follows.
- Reset asserted mid-CLICK -> same-cycle async clear: tone_en=0, grant=000, db_estado=0. With TONE_ARBITER_MUTE_EN, mudo=1 during PLAY_JOG -> tone_en=0 while grant stays 001.

Source files
------------

// File: rtl/fpgaudio_pkg.sv
// Shared types and constants for the fpgaudio tone path: arbiter state encoding,
// grant one-hot codes, default note width and the silence code.
package fpgaudio_pkg;

    localparam int NOTE_W_DEF    = 4;
    localparam int NOTA_SILENCIO = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PLAY_JOG = 3'd1,
        ST_PLAY_MEM = 3'd2,
        ST_CLICK    = 3'd3,
        ST_GAP      = 3'd4
    } arb_state_t;

    localparam logic [2:0] GNT_NONE  = 3'b000;
    localparam logic [2:0] GNT_JOG   = 3'b001;
    localparam logic [2:0] GNT_MEM   = 3'b010;
    localparam logic [2:0] GNT_METRO = 3'b100;

    // Counter width able to hold 0..max_val-1 (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/tone_arb_timer.sv
// Loadable up-counter with synchronous clear, count enable and a terminal-count
// flag that is high while the count equals MAX_COUNT-1.
module tone_arb_timer
    import fpgaudio_pkg::*;
#(
    parameter int MAX_COUNT = 4,
    localparam int W        = cnt_width(MAX_COUNT)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == W'(MAX_COUNT - 1));

endmodule

// File: rtl/tone_arbiter.sv
// Fixed-priority arbiter (jog > mem > metronome) sharing one tone generator, with a
// silence gap between articulations and a timed click. Optional TONE_ARBITER_MUTE_EN.
module tone_arbiter
    import fpgaudio_pkg::*;
#(
    parameter int              NOTE_W       = NOTE_W_DEF,
    parameter int              GAP_CYCLES   = 500000,
    parameter int              CLICK_CYCLES = 2500000,
    parameter logic [NOTE_W-1:0] CLICK_NOTE = NOTE_W'(4'hF)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
`ifdef TONE_ARBITER_MUTE_EN
    input  logic              mudo,
`endif
    input  logic              req_jog,
    input  logic [NOTE_W-1:0] nota_jog,
    input  logic              req_mem,
    input  logic [NOTE_W-1:0] nota_mem,
    input  logic              pulso_metro,
    output logic              tone_en,
    output logic [NOTE_W-1:0] tone_sel,
    output logic [2:0]        grant,
    output logic              click_perdido,
    output logic [2:0]        db_estado
);

    arb_state_t        state, state_d;
    logic [NOTE_W-1:0] nota_reg;
    logic              click_pend, click_pend_d;
    logic              click_entry, discard;
    logic              gap_tc, click_tc, stale_tc;
    logic              tone_en_fsm;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            nota_reg   <= NOTE_W'(NOTA_SILENCIO);
            click_pend <= 1'b0;
        end else begin
            state      <= state_d;
            click_pend <= click_pend_d;
            if (!enable) begin
                nota_reg <= NOTE_W'(NOTA_SILENCIO);
            end else if (state == ST_IDLE && state_d == ST_PLAY_JOG) begin
                nota_reg <= nota_jog;
            end else if (state == ST_IDLE && state_d == ST_PLAY_MEM) begin
                nota_reg <= nota_mem;
            end
        end
    end

    always_comb begin
        state_d = state;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_jog)         state_d = ST_PLAY_JOG;
                    else if (req_mem)    state_d = ST_PLAY_MEM;
                    else if (click_pend) state_d = ST_CLICK;
                end
                ST_PLAY_JOG: begin
                    if (!req_jog || nota_jog != nota_reg) state_d = ST_GAP;
                end
                ST_PLAY_MEM: begin
                    if (req_jog || !req_mem || nota_mem != nota_reg) state_d = ST_GAP;
                end
                ST_CLICK: begin
                    if (req_jog || req_mem || click_tc) state_d = ST_GAP;
                end
                ST_GAP: begin
                    if (gap_tc) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A pulse coinciding with CLICK entry is absorbed by that click; a pulse
    // coinciding with a stale discard re-arms the pending click.
    always_comb begin
        click_entry  = (state != ST_CLICK) && (state_d == ST_CLICK);
        discard      = click_pend && stale_tc && !click_entry;
        click_pend_d = click_pend;
        if (!enable) begin
            click_pend_d = 1'b0;
        end else if (click_entry) begin
            click_pend_d = 1'b0;
        end else if (pulso_metro) begin
            click_pend_d = 1'b1;
        end else if (discard) begin
            click_pend_d = 1'b0;
        end
    end

    assign click_perdido = enable && discard;

    always_comb begin
        tone_en_fsm = 1'b0;
        tone_sel    = NOTE_W'(NOTA_SILENCIO);
        grant       = GNT_NONE;
        case (state)
            ST_PLAY_JOG: begin
                tone_en_fsm = 1'b1;
                tone_sel    = nota_reg;
                grant       = GNT_JOG;
            end
            ST_PLAY_MEM: begin
                tone_en_fsm = 1'b1;
                tone_sel    = nota_reg;
                grant       = GNT_MEM;
            end
            ST_CLICK: begin
                tone_en_fsm = 1'b1;
                tone_sel    = CLICK_NOTE;
                grant       = GNT_METRO;
            end
            default: ;
        endcase
    end

`ifdef TONE_ARBITER_MUTE_EN
    assign tone_en = tone_en_fsm && !mudo;
`else
    assign tone_en = tone_en_fsm;
`endif

    assign db_estado = state;

    tone_arb_timer #(.MAX_COUNT(GAP_CYCLES)) u_gap_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (!enable || state != ST_GAP),
        .load     (1'b0),
        .load_val ('0),
        .en       (state == ST_GAP),
        .tc       (gap_tc)
    );

    tone_arb_timer #(.MAX_COUNT(CLICK_CYCLES)) u_click_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (!enable || state != ST_CLICK),
        .load     (1'b0),
        .load_val ('0),
        .en       (state == ST_CLICK),
        .tc       (click_tc)
    );

    // Staleness restarts whenever the pending click is served, dropped or re-armed.
    tone_arb_timer #(.MAX_COUNT(CLICK_CYCLES)) u_stale_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (!enable || !click_pend || discard || click_entry),
        .load     (1'b0),
        .load_val ('0),
        .en       (click_pend),
        .tc       (stale_tc)
    );

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed bench for tone_arbiter with GAP_CYCLES=4 and CLICK_CYCLES=8.
module tb_tone_arbiter;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       req_jog;
    logic [3:0] nota_jog;
    logic       req_mem;
    logic [3:0] nota_mem;
    logic       pulso_metro;
    logic       tone_en;
    logic [3:0] tone_sel;
    logic [2:0] grant;
    logic       click_perdido;
    logic [2:0] db_estado;
`ifdef TONE_ARBITER_MUTE_EN
    logic       mudo;
`endif

    int n_checks = 0;
    int n_err    = 0;

    tone_arbiter #(
        .NOTE_W       (4),
        .GAP_CYCLES   (4),
        .CLICK_CYCLES (8),
        .CLICK_NOTE   (4'hF)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
`ifdef TONE_ARBITER_MUTE_EN
        .mudo          (mudo),
`endif
        .req_jog       (req_jog),
        .nota_jog      (nota_jog),
        .req_mem       (req_mem),
        .nota_mem      (nota_mem),
        .pulso_metro   (pulso_metro),
        .tone_en       (tone_en),
        .tone_sel      (tone_sel),
        .grant         (grant),
        .click_perdido (click_perdido),
        .db_estado     (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] st, input logic en,
                           input logic [3:0] sel, input logic [2:0] gnt);
        chk({tag, ".st"},  32'(db_estado), 32'(st));
        chk({tag, ".en"},  32'(tone_en),   32'(en));
        chk({tag, ".sel"}, 32'(tone_sel),  32'(sel));
        chk({tag, ".gnt"}, 32'(grant),     32'(gnt));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; req_jog = 1'b0; nota_jog = 4'd0;
        req_mem = 1'b0; nota_mem = 4'd0; pulso_metro = 1'b0;
`ifdef TONE_ARBITER_MUTE_EN
        mudo = 1'b0;
`endif
        tick(2);
        chk_out("reset", 3'd0, 1'b0, 4'd0, 3'b000);
        chk("reset.perdido", 32'(click_perdido), 32'd0);
        reset = 1'b0; enable = 1'b1;
        tick(2);
        chk_out("idle", 3'd0, 1'b0, 4'd0, 3'b000);

        // Memory playback with one-cycle latency, then a 4-cycle gap.
        req_mem = 1'b1; nota_mem = 4'd5;
        tick(1);
        chk_out("mem.play", 3'd2, 1'b1, 4'd5, 3'b010);
        tick(5);
        chk_out("mem.hold", 3'd2, 1'b1, 4'd5, 3'b010);
        req_mem = 1'b0;
        tick(1);
        chk_out("mem.gap0", 3'd4, 1'b0, 4'd0, 3'b000);
        tick(3);
        chk_out("mem.gap3", 3'd4, 1'b0, 4'd0, 3'b000);
        tick(1);
        chk_out("mem.idle", 3'd0, 1'b0, 4'd0, 3'b000);

        // Jog preempts memory; gap, idle re-arbitration, then jog plays note 9.
        req_mem = 1'b1; nota_mem = 4'd5;
        tick(1);
        chk_out("pre.mem", 3'd2, 1'b1, 4'd5, 3'b010);
        req_jog = 1'b1; nota_jog = 4'd9;
        tick(1);
        chk_out("pre.gap", 3'd4, 1'b0, 4'd0, 3'b000);
        tick(4);
        chk_out("pre.idle", 3'd0, 1'b0, 4'd0, 3'b000);
        tick(1);
        chk_out("pre.jog", 3'd1, 1'b1, 4'd9, 3'b001);
        req_jog = 1'b0; req_mem = 1'b0;
        tick(5);
        chk_out("pre.noresume", 3'd0, 1'b0, 4'd0, 3'b000);
        tick(1);
        chk_out("pre.stayidle", 3'd0, 1'b0, 4'd0, 3'b000);

        // Metronome click: second pulse while pending is absorbed.
        pulso_metro = 1'b1;
        tick(1);
        chk_out("clk.pend", 3'd0, 1'b0, 4'd0, 3'b000);
        tick(1);
        pulso_metro = 1'b0;
        chk_out("clk.start", 3'd3, 1'b1, 4'hF, 3'b100);
        tick(7);
        chk_out("clk.last", 3'd3, 1'b1, 4'hF, 3'b100);
        tick(1);
        chk_out("clk.gap", 3'd4, 1'b0, 4'd0, 3'b000);
        tick(4);
        chk_out("clk.idle", 3'd0, 1'b0, 4'd0, 3'b000);
        tick(2);
        chk_out("clk.noqueue", 3'd0, 1'b0, 4'd0, 3'b000);

        // Re-articulation: 2, 2, 7 gaps only on the change.
        req_jog = 1'b1; nota_jog = 4'd2;
        tick(1);
        chk_out("art.2a", 3'd1, 1'b1, 4'd2, 3'b001);
        tick(2);
        chk_out("art.2b", 3'd1, 1'b1, 4'd2, 3'b001);
        nota_jog = 4'd7;
        tick(1);
        chk_out("art.gap", 3'd4, 1'b0, 4'd0, 3'b000);
        tick(5);
        chk_out("art.7", 3'd1, 1'b1, 4'd7, 3'b001);

        // Note 0 forwarded as-is while granted.
        nota_jog = 4'd0;
        tick(6);
        chk_out("art.zero", 3'd1, 1'b1, 4'd0, 3'b001);

        // Stale click discarded after 8 pending cycles while jog holds the tone.
        nota_jog = 4'd3;
        tick(6);
        chk_out("stale.jog", 3'd1, 1'b1, 4'd3, 3'b001);
        pulso_metro = 1'b1;
        tick(1);
        pulso_metro = 1'b0;
        chk("stale.p0", 32'(click_perdido), 32'd0);
        tick(6);
        chk("stale.p6", 32'(click_perdido), 32'd0);
        tick(1);
        chk("stale.p7", 32'(click_perdido), 32'd1);
        tick(1);
        chk("stale.p8", 32'(click_perdido), 32'd0);
        req_jog = 1'b0;
        tick(6);
        chk_out("stale.noclick", 3'd0, 1'b0, 4'd0, 3'b000);

        // Enable low forces IDLE without a gap.
        req_jog = 1'b1; nota_jog = 4'd6;
        tick(1);
        chk_out("en.jog", 3'd1, 1'b1, 4'd6, 3'b001);
        enable = 1'b0;
        tick(1);
        chk_out("en.off", 3'd0, 1'b0, 4'd0, 3'b000);
        tick(1);
        chk_out("en.offhold", 3'd0, 1'b0, 4'd0, 3'b000);
        enable = 1'b1;
        tick(1);
        chk_out("en.on", 3'd1, 1'b1, 4'd6, 3'b001);

`ifdef TONE_ARBITER_MUTE_EN
        mudo = 1'b1;
        #1;
        chk_out("mute.on", 3'd1, 1'b0, 4'd6, 3'b001);
        mudo = 1'b0;
        #1;
        chk_out("mute.off", 3'd1, 1'b1, 4'd6, 3'b001);
`endif
        req_jog = 1'b0;
        tick(6);
        chk_out("en.idle", 3'd0, 1'b0, 4'd0, 3'b000);

        // Asynchronous reset in the middle of a click.
        pulso_metro = 1'b1;
        tick(1);
        pulso_metro = 1'b0;
        tick(3);
        chk_out("rst.click", 3'd3, 1'b1, 4'hF, 3'b100);
        #1 reset = 1'b1;
        #1;
        chk_out("rst.async", 3'd0, 1'b0, 4'd0, 3'b000);
        tick(1);
        reset = 1'b0;
        tick(2);
        chk_out("rst.after", 3'd0, 1'b0, 4'd0, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
